shift_seq_ctrl: RTL

//   Sequencer for the 8-bit load/shift register. Accepts one parallel word per

---
 rtl/shift_seq_ctrl.sv | 96 +++++++++
 1 files changed

// File: rtl/shift_seq_ctrl.sv
// Load/shift sequencer: accepts one word per handshake, pulses ld, then issues
// WIDTH sh pulses spaced div+1 clocks apart and returns the shifted-in word.
module shift_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic [DIV_W-1:0] div,
  input  logic             abort,
  output logic [WIDTH-1:0] pin,
  output logic             ld,
  output logic             sh,
  input  logic [WIDTH-1:0] pout_in,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, SHIFT, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [DIV_W-1:0] div_lat;
  logic [DIV_W-1:0] div_cnt;

  // Strobes come straight off the state register so they are glitch-free and
  // drop the instant reset forces IDLE.
  assign ld          = (state == LOAD);
  assign sh          = (state == SHIFT);
  assign busy        = (state != IDLE);
  assign start_ready = (state == IDLE) && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pin      <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      bit_cnt  <= '0;
      div_lat  <= '0;
      div_cnt  <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start_valid && start_ready) begin
            pin     <= tx_data;
            div_lat <= div;
            bit_cnt <= '0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (abort)                state <= IDLE;
          else if (div_lat == '0)   state <= SHIFT;
          else begin
            div_cnt <= div_lat - DIV_W'(1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (abort)                state <= IDLE;
          else if (div_cnt == '0)   state <= SHIFT;
          else                      div_cnt <= div_cnt - DIV_W'(1);
        end
        SHIFT: begin
          // The pulse has already gone out this cycle, so it is counted even on abort.
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (abort)                   state <= IDLE;
          else if (bit_cnt == LAST_BIT) state <= DONE;
          else if (div_lat == '0)      state <= SHIFT;
          else begin
            div_cnt <= div_lat - DIV_W'(1);
            state   <= WAIT;
          end
        end
        DONE: begin
          state <= IDLE;
          if (!abort) begin
            rx_data  <= pout_in;
            rx_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
